// File: rtl/ab_key_filter.sv
// Two-channel key input stage: 2-flop synchroniser plus debounce FSM per channel,
// producing clean levels po_a/po_b and a one-cycle po_flag strobe on any accepted change.
module ab_key_filter #(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pi_key_a,
  input  logic pi_key_b,
  output logic po_a,
  output logic po_b,
  output logic po_flag
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);

  // Index 0 is channel A, index 1 is channel B.
  logic [1:0]       raw_s;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  state_t           state_q [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [1:0]       po_q;
  logic [1:0]       chg_s;
  logic             flag_q;

  assign raw_s = {pi_key_b, pi_key_a};

  // Two-stage synchroniser for both raw key levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // A channel accepts a new level on this edge when its window has fully elapsed;
  // looking one edge ahead lets the strobe line up with the first new po value.
  always_comb begin
    chg_s = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (cnt_q[ch] == CNT_MAX_C) begin
        if (state_q[ch] == S_RISE) begin
          chg_s[ch] = sync2_q[ch];
        end else if (state_q[ch] == S_FALL) begin
          chg_s[ch] = ~sync2_q[ch];
        end else begin
          chg_s[ch] = 1'b0;
        end
      end else begin
        chg_s[ch] = 1'b0;
      end
    end
  end

  // Per-channel debounce FSM with registered level outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= S_LOW;
        cnt_q[ch]   <= CNT_ZERO_C;
      end
      po_q <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        case (state_q[ch])
          S_LOW: begin
            if (sync2_q[ch]) begin
              state_q[ch] <= S_RISE;
              cnt_q[ch]   <= CNT_ZERO_C;
            end
          end
          S_RISE: begin
            if (!sync2_q[ch]) begin
              state_q[ch] <= S_LOW;
              cnt_q[ch]   <= CNT_ZERO_C;
            end else if (cnt_q[ch] == CNT_MAX_C) begin
              state_q[ch] <= S_HIGH;
              cnt_q[ch]   <= CNT_ZERO_C;
              po_q[ch]    <= 1'b1;
            end else begin
              cnt_q[ch]   <= cnt_q[ch] + CNT_ONE_C;
            end
          end
          S_HIGH: begin
            if (!sync2_q[ch]) begin
              state_q[ch] <= S_FALL;
              cnt_q[ch]   <= CNT_ZERO_C;
            end
          end
          S_FALL: begin
            if (sync2_q[ch]) begin
              state_q[ch] <= S_HIGH;
              cnt_q[ch]   <= CNT_ZERO_C;
            end else if (cnt_q[ch] == CNT_MAX_C) begin
              state_q[ch] <= S_LOW;
              cnt_q[ch]   <= CNT_ZERO_C;
              po_q[ch]    <= 1'b0;
            end else begin
              cnt_q[ch]   <= cnt_q[ch] + CNT_ONE_C;
            end
          end
          default: begin
            state_q[ch] <= S_LOW;
            cnt_q[ch]   <= CNT_ZERO_C;
            po_q[ch]    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Single strobe covers simultaneous changes on both channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= |chg_s;
    end
  end

  assign po_a    = po_q[0];
  assign po_b    = po_q[1];
  assign po_flag = flag_q;

endmodule

// File: tb/tb_ab_key_filter.sv
// Directed self-checking bench for ab_key_filter with CNT_MAX=3.
module tb_ab_key_filter;

  logic clk;
  logic rst_n;
  logic pi_key_a;
  logic pi_key_b;
  logic po_a;
  logic po_b;
  logic po_flag;

  int n_cmp;
  int n_bad;
  int flag_cnt;

  ab_key_filter #(.CNT_MAX(3), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pi_key_a(pi_key_a),
    .pi_key_b(pi_key_b),
    .po_a    (po_a),
    .po_b    (po_b),
    .po_flag (po_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each and counting flag pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (po_flag === 1'b1) flag_cnt++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    flag_cnt = 0;
    rst_n = 1'b0;
    pi_key_a = 1'b0;
    pi_key_b = 1'b0;
    tick(3);
    chk("rst_po_a", {31'd0, po_a}, 32'd0);
    chk("rst_po_b", {31'd0, po_b}, 32'd0);
    chk("rst_flag", {31'd0, po_flag}, 32'd0);

    // A rises right after reset release: po_a at edge 7
    rst_n = 1'b1;
    pi_key_a = 1'b1;
    flag_cnt = 0;
    tick(6);
    chk("rise_e6_po_a", {31'd0, po_a}, 32'd0);
    chk("rise_e6_flags", flag_cnt, 32'd0);
    tick(1);
    chk("rise_e7_po_a", {31'd0, po_a}, 32'd1);
    chk("rise_e7_flag", {31'd0, po_flag}, 32'd1);
    tick(1);
    chk("rise_e8_flag", {31'd0, po_flag}, 32'd0);
    chk("rise_e8_po_a", {31'd0, po_a}, 32'd1);
    chk("rise_po_b", {31'd0, po_b}, 32'd0);

    // A falls and holds: po_a=0 at edge 7
    pi_key_a = 1'b0;
    flag_cnt = 0;
    tick(6);
    chk("fall_e6_po_a", {31'd0, po_a}, 32'd1);
    tick(1);
    chk("fall_e7_po_a", {31'd0, po_a}, 32'd0);
    chk("fall_e7_flag", {31'd0, po_flag}, 32'd1);
    chk("fall_flags", flag_cnt, 32'd1);
    tick(3);

    // 4-cycle pulse is rejected
    flag_cnt = 0;
    pi_key_a = 1'b1;
    tick(4);
    pi_key_a = 1'b0;
    tick(10);
    chk("p4_po_a", {31'd0, po_a}, 32'd0);
    chk("p4_flags", flag_cnt, 32'd0);

    // 5-cycle pulse is accepted at edge 7
    flag_cnt = 0;
    pi_key_a = 1'b1;
    tick(5);
    pi_key_a = 1'b0;
    tick(1);
    chk("p5_e6_po_a", {31'd0, po_a}, 32'd0);
    tick(1);
    chk("p5_e7_po_a", {31'd0, po_a}, 32'd1);
    chk("p5_flags", flag_cnt, 32'd1);
    tick(10);
    chk("p5_back_low", {31'd0, po_a}, 32'd0);

    // Bounce 1,0,1,0 then stable 1
    flag_cnt = 0;
    pi_key_a = 1'b1; tick(1);
    pi_key_a = 1'b0; tick(1);
    pi_key_a = 1'b1; tick(1);
    pi_key_a = 1'b0; tick(1);
    pi_key_a = 1'b1;
    tick(6);
    chk("bnc_e10_po_a", {31'd0, po_a}, 32'd0);
    tick(1);
    chk("bnc_e11_po_a", {31'd0, po_a}, 32'd1);
    chk("bnc_e11_flag", {31'd0, po_flag}, 32'd1);
    tick(3);
    chk("bnc_flags", flag_cnt, 32'd1);
    pi_key_a = 1'b0;
    tick(8);
    chk("bnc_low", {31'd0, po_a}, 32'd0);

    // A and B together: one strobe
    flag_cnt = 0;
    pi_key_a = 1'b1;
    pi_key_b = 1'b1;
    tick(6);
    chk("ab_e6_po_b", {31'd0, po_b}, 32'd0);
    tick(1);
    chk("ab_e7_po_a", {31'd0, po_a}, 32'd1);
    chk("ab_e7_po_b", {31'd0, po_b}, 32'd1);
    chk("ab_e7_flag", {31'd0, po_flag}, 32'd1);
    tick(1);
    chk("ab_e8_flag", {31'd0, po_flag}, 32'd0);
    chk("ab_flags", flag_cnt, 32'd1);
    pi_key_a = 1'b0;
    pi_key_b = 1'b0;
    tick(10);
    chk("ab_low", {30'd0, po_b, po_a}, 32'd0);

    // B one cycle behind A: two adjacent strobes
    flag_cnt = 0;
    pi_key_a = 1'b1;
    tick(1);
    pi_key_b = 1'b1;
    tick(6);
    chk("abd_e7_po_a", {31'd0, po_a}, 32'd1);
    chk("abd_e7_po_b", {31'd0, po_b}, 32'd0);
    chk("abd_e7_flag", {31'd0, po_flag}, 32'd1);
    tick(1);
    chk("abd_e8_po_b", {31'd0, po_b}, 32'd1);
    chk("abd_e8_flag", {31'd0, po_flag}, 32'd1);
    tick(1);
    chk("abd_e9_flag", {31'd0, po_flag}, 32'd0);
    chk("abd_flags", flag_cnt, 32'd2);
    pi_key_a = 1'b0;
    pi_key_b = 1'b0;
    tick(10);

    // Reset mid-count, then full new window after release
    pi_key_a = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #2;
    chk("rmid_po_a", {31'd0, po_a}, 32'd0);
    chk("rmid_flag", {31'd0, po_flag}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    flag_cnt = 0;
    tick(1);
    chk("rrel_e1_flag", {31'd0, po_flag}, 32'd0);
    tick(5);
    chk("rrel_e6_po_a", {31'd0, po_a}, 32'd0);
    tick(1);
    chk("rrel_e7_po_a", {31'd0, po_a}, 32'd1);
    chk("rrel_flags", flag_cnt, 32'd1);

    // Async reset while po_a=1, without a clock edge
    tick(2);
    rst_n = 1'b0;
    #2;
    chk("rhi_po_a", {31'd0, po_a}, 32'd0);
    chk("rhi_po_b", {31'd0, po_b}, 32'd0);
    chk("rhi_flag", {31'd0, po_flag}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    flag_cnt = 0;
    tick(6);
    chk("rhi2_e6_po_a", {31'd0, po_a}, 32'd0);
    chk("rhi2_e6_flags", flag_cnt, 32'd0);
    tick(1);
    chk("rhi2_e7_po_a", {31'd0, po_a}, 32'd1);
    chk("rhi2_e7_flag", {31'd0, po_flag}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ab_key_filter.md
Name: ab_key_filter

Overview:
- Upstream input stage for the AND-gate datapath.
- Takes two raw, asynchronous switch/key levels and synchronises each into clk.
- Debounces each one independently with a per-channel filter FSM.
- Outputs clean levels po_a/po_b plus a one-cycle po_flag strobe, which go straight into the downstream stage's pi_a/pi_b/pi_flag inputs.

Parameters:
- CNT_MAX, 999_999, stability window: a new level must hold for CNT_MAX+2 synchronised cycles (20 ms at 50 MHz); use 3 in simulation.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > CNT_MAX.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- pi_key_a  input  1  raw level A, asynchronous to clk, may bounce
- pi_key_b  input  1  raw level B, asynchronous to clk, may bounce
- po_a  output  1  debounced level A
- po_b  output  1  debounced level B
- po_flag  output  1  one-cycle strobe: po_a and/or po_b just took a new value

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n=0, independent of clk.
  - Reset values: sync flops 0, counters 0, FSMs S_LOW, po_a=0, po_b=0, po_flag=0.
  - Release is sampled on clk; no flag is generated by reset entry or exit.
- Synchroniser:
  - Each raw input passes through 2 flops (q1, q2); only q2 feeds the FSM.
- Per-channel FSM (identical for A and B), 2-bit state, CNT_W-bit counter:
  - S_LOW (po=0): q2=1 -> S_RISE, cnt<=0; else stay.
  - S_RISE: q2=0 -> S_LOW, cnt<=0, glitch discarded with no output change. q2=1 and cnt==CNT_MAX -> S_HIGH, po<=1, chg<=1. Otherwise cnt<=cnt+1.
  - S_HIGH (po=1): q2=0 -> S_FALL, cnt<=0; else stay.
  - S_FALL: mirror of S_RISE; q2=1 -> S_HIGH, cnt<=0; q2=0 and cnt==CNT_MAX -> S_LOW, po<=0, chg<=1.
  - Counter never exceeds CNT_MAX and never wraps.
  - Illegal state encodings recover to S_LOW on the next edge.
- Timing:
  - Raw change settling before edge 1 -> q2 changes at edge 2 -> filter entered at edge 3 -> po changes at edge CNT_MAX+4.
  - A pulse is accepted iff it stays stable for >= CNT_MAX+2 consecutive cycles at q2.
- Flag:
  - po_flag is registered and equals chg_a | chg_b, valid in the same cycle as the first new po value.
  - po_flag is high for exactly 1 cycle.
  - If A and B both change on the same edge, a single pulse is issued.
  - Changes on different edges give separate pulses, even when adjacent.
- po_a/po_b are held constant between accepted transitions.
- No combinational path from inputs to outputs.

Test Plan (CNT_MAX=3):
- Reset, then raw A rises before edge 1 and holds -> po_a=1 and po_flag=1 at edge 7; po_flag=0 at edge 8; po_b stays 0 throughout.
- Raw A pulses high for 4 cycles, then low -> po_a stays 0 and po_flag never asserts. Repeat with 5 cycles -> po_a=1 with one flag pulse.
- Bounce 1,0,1,0,1 (1 cycle each), then stable 1 -> po_a rises exactly 5 cycles after the final 1 reaches q2; exactly one po_flag pulse.
- A and B rise on the same cycle -> po_a=po_b=1 on the same edge, single 1-cycle po_flag. B delayed by 1 cycle -> two flag pulses on consecutive edges.
- po_a=1, A falls and holds -> po_a=0 at edge CNT_MAX+4 after the change, with one flag pulse.
- Assert rst_n=0 mid-count (S_RISE, cnt=2) and while po_a=1 -> all outputs 0 immediately without a clock edge. Release with raw still high -> full new window (edge 7 after release) before po_a=1; no flag at release.
